// File: rtl/fp_align_unpack.sv
// fp_align_unpack
//   Front end of the single-precision add/sub datapath. It takes two IEEE-754
//   operands and unpacks them. It picks the larger magnitude and right-aligns
//   the smaller one with an iterative shifter that moves SHIFT_STEP bits per
//   cycle. The result is two 28-bit extended mantissas {hidden, frac, 4'b0}
//   plus a 2-bit summary of the bits shifted out.
//
// Ports
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   in_valid      operands a/b/operator valid
//   in_ready      block can accept operands (IDLE only)
//   a, b          IEEE-754 single operands
//   operator      0 = A+B, 1 = A-B
//   out_valid     aligned result valid, held until out_ready
//   out_ready     downstream accepts result
//   exp           common (larger) effective exponent
//   sign          sign of the larger-magnitude operand
//   eff_sub       effective subtraction flag
//   mantis_big    larger operand mantissa {hidden, frac, 4'b0}
//   mantis_small  smaller operand mantissa after alignment
//   loss          [0] last bit shifted out, [1] OR of all earlier shifted-out bits
//   special       an operand has exponent 8'hFF; no alignment performed
module fp_align_unpack #(
   parameter int SHIFT_STEP = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        operator,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  exp,
   output logic        sign,
   output logic        eff_sub,
   output logic [27:0] mantis_big,
   output logic [27:0] mantis_small,
   output logic [1:0]  loss,
   output logic        special
);

   typedef enum logic [1:0] {IDLE, CMP, SHIFT, DONE} state_t;

   localparam logic [4:0] STEP5 = 5'(SHIFT_STEP);

   state_t state, state_nxt;

   logic [31:0] a_r, b_r;
   logic        op_r;

   logic [7:0]  exp_a, exp_b, exp_diff;
   logic        hid_a, hid_b, a_big, is_special;
   logic [27:0] man_a, man_b, cmp_big, cmp_small;
   logic [7:0]  cmp_exp;
   logic        cmp_sign;
   logic [4:0]  cmp_dist;

   logic [7:0]  w_exp;
   logic        w_sign, w_eff_sub, w_special;
   logic [27:0] w_big, w_small, sh_small;
   logic [1:0]  w_loss, sh_loss;
   logic [4:0]  remaining, step_n, rem_nxt;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   // Unpack both operands. A zero exponent field is a subnormal, so it gets no
   // hidden bit and an effective exponent of 1. The magnitude order follows
   // from {eff_exp, hidden, frac}, and A wins ties. Special operands keep A/B
   // in place and force the exponent to all ones.
   always_comb begin
      exp_a      = (a_r[30:23] == 8'd0) ? 8'd1 : a_r[30:23];
      exp_b      = (b_r[30:23] == 8'd0) ? 8'd1 : b_r[30:23];
      hid_a      = |a_r[30:23];
      hid_b      = |b_r[30:23];
      man_a      = {hid_a, a_r[22:0], 4'b0000};
      man_b      = {hid_b, b_r[22:0], 4'b0000};
      a_big      = {exp_a, hid_a, a_r[22:0]} >= {exp_b, hid_b, b_r[22:0]};
      is_special = (&a_r[30:23]) | (&b_r[30:23]);
      cmp_sign   = a_big ? a_r[31] : (b_r[31] ^ op_r);
      exp_diff   = a_big ? (exp_a - exp_b) : (exp_b - exp_a);
      cmp_dist   = (exp_diff > 8'd31) ? 5'd31 : exp_diff[4:0];
      if (is_special) begin
         cmp_big   = man_a;
         cmp_small = man_b;
         cmp_exp   = 8'hFF;
         cmp_dist  = 5'd0;
      end else begin
         cmp_big   = a_big ? man_a : man_b;
         cmp_small = a_big ? man_b : man_a;
         cmp_exp   = a_big ? exp_a : exp_b;
      end
   end

   // One shifter step. Bits leave bit 0 one at a time so the loss flags follow
   // the real order: the previous last-out bit folds into the sticky flag.
   always_comb begin
      sh_small = w_small;
      sh_loss  = w_loss;
      for (int i = 0; i < SHIFT_STEP; i++) begin
         if (i < int'(remaining)) begin
            sh_loss  = {sh_loss[1] | sh_loss[0], sh_small[0]};
            sh_small = sh_small >> 1;
         end
      end
      step_n  = (remaining < STEP5) ? remaining : STEP5;
      rem_nxt = remaining - step_n;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic. The pipeline holds one operation at a time. DONE
   // returns to IDLE only after acceptance, so a new operand pair cannot be
   // taken in the same cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = CMP;
         CMP:     state_nxt = (is_special || cmp_dist == 5'd0) ? DONE : SHIFT;
         SHIFT:   if (rem_nxt == 5'd0) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath. The working registers hold intermediate shift results. The
   // visible outputs load only on entry to DONE, so they stay steady while a
   // result waits and never show a partly shifted value. Reset clears
   // everything and drops any operation in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_r          <= '0;
         b_r          <= '0;
         op_r         <= 1'b0;
         w_exp        <= '0;
         w_sign       <= 1'b0;
         w_eff_sub    <= 1'b0;
         w_special    <= 1'b0;
         w_big        <= '0;
         w_small      <= '0;
         w_loss       <= '0;
         remaining    <= '0;
         exp          <= '0;
         sign         <= 1'b0;
         eff_sub      <= 1'b0;
         mantis_big   <= '0;
         mantis_small <= '0;
         loss         <= '0;
         special      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_r  <= a;
                  b_r  <= b;
                  op_r <= operator;
               end
            end
            CMP: begin
               w_exp     <= cmp_exp;
               w_sign    <= cmp_sign;
               w_eff_sub <= a_r[31] ^ b_r[31] ^ op_r;
               w_special <= is_special;
               w_big     <= cmp_big;
               w_small   <= cmp_small;
               w_loss    <= 2'b00;
               remaining <= cmp_dist;
               if (is_special || cmp_dist == 5'd0) begin
                  exp          <= cmp_exp;
                  sign         <= cmp_sign;
                  eff_sub      <= a_r[31] ^ b_r[31] ^ op_r;
                  special      <= is_special;
                  mantis_big   <= cmp_big;
                  mantis_small <= cmp_small;
                  loss         <= 2'b00;
               end
            end
            SHIFT: begin
               w_small   <= sh_small;
               w_loss    <= sh_loss;
               remaining <= rem_nxt;
               if (rem_nxt == 5'd0) begin
                  exp          <= w_exp;
                  sign         <= w_sign;
                  eff_sub      <= w_eff_sub;
                  special      <= w_special;
                  mantis_big   <= w_big;
                  mantis_small <= sh_small;
                  loss         <= sh_loss;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
